io_mailbox_dev: RTL

Bus-target peripheral on the CPU's external I/O bus: it responds when the CPU asserts `select_dev`, the strobe-driven side opposite the CPU's I/O interface. It holds two 16-bit FIFOs. TX is filled by CPU writes and drained on a valid/ready output stream; RX is filled from a valid/ready input stream and drained by CPU reads. Status and control registers and a level interrupt let firmware poll the mailbox or be interrupted by it.

---
 rtl/io_mailbox_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/io_mailbox_dev.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/io_mailbox_pkg.sv
// Shared register map, bit positions and helpers for the I/O mailbox.
package io_mailbox_pkg;

    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_RX_CNT   = 0;
    localparam int ST_TX_CNT   = 4;
    localparam int ST_RX_EMPTY = 8;
    localparam int ST_TX_FULL  = 9;
    localparam int ST_TX_OVF   = 10;
    localparam int ST_RX_UDF   = 11;

    localparam int CTRL_IRQ_RX   = 0;
    localparam int CTRL_IRQ_TXE  = 1;
    localparam int CTRL_CLR      = 12;
    localparam int CTRL_FLUSH_RX = 14;
    localparam int CTRL_FLUSH_TX = 15;

    // Occupancy fields are only 4 bits wide; larger depths pin at 15.
    function automatic logic [3:0] sat_nib(input logic [31:0] v);
        return (v > 32'd15) ? 4'hF : 4'(v);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a push into a full FIFO is dropped even
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign head   = r_mem[r_rd_ptr];
    assign count  = r_count;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !flush && !reset) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/io_mailbox_dev.sv
// CPU I/O-bus mailbox target: TX/RX FIFOs behind a 4-register map with
// strobe edge detection, byte-lane merge, sticky flags and a level irq.
module io_mailbox_dev
    import io_mailbox_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [14:0] address,
    inout  wire  [15:0] data,
    input  logic        memNotRead,
    input  logic        memNotWrite,
    input  logic        csh_n,
    input  logic        csl_n,
    input  logic        select_dev,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);
    logic          r_wr_act;
    logic          r_rd_act;
    logic          r_pop_pend;
    logic          r_en_rx;
    logic          r_en_txe;
    logic          r_tx_ovf;
    logic          r_rx_udf;
    logic          r_irq;

    logic          w_lane_any;
    logic          w_wr_commit;
    logic          w_tx_wr;
    logic          w_ctrl_wr;
    logic          w_clr;
    logic          w_flush_rx;
    logic          w_flush_tx;
    logic          w_rd_start;
    logic          w_rd_drive;
    logic          w_rx_pop;
    logic          w_tx_pop;
    logic [15:0]   w_tx_wdata;
    logic [15:0]   w_rd_val;
    logic [15:0]   w_rx_head;
    logic [CW-1:0] w_rx_count;
    logic [CW-1:0] w_tx_count;
    logic          w_rx_empty;
    logic          w_rx_full;
    logic          w_tx_empty;
    logic          w_tx_full;
    logic          w_unused;

    assign w_unused = ^address[14:2];

    assign w_lane_any  = ~(csh_n & csl_n);
    // *_act resets to 1 so a strobe held through reset needs a release first.
    assign w_wr_commit = ~memNotWrite & select_dev & ~r_wr_act & w_lane_any;
    assign w_tx_wr     = w_wr_commit & (address[1:0] == REG_TXDATA);
    assign w_ctrl_wr   = w_wr_commit & (address[1:0] == REG_CTRL);
    assign w_clr       = w_ctrl_wr & ~csh_n & data[CTRL_CLR];
    assign w_flush_rx  = w_ctrl_wr & ~csh_n & data[CTRL_FLUSH_RX];
    assign w_flush_tx  = w_ctrl_wr & ~csh_n & data[CTRL_FLUSH_TX];
    assign w_tx_wdata  = {csh_n ? 8'h00 : data[15:8], csl_n ? 8'h00 : data[7:0]};

    assign w_rd_drive  = select_dev & ~memNotRead & w_lane_any;
    assign w_rd_start  = w_rd_drive & ~r_rd_act & (address[1:0] == REG_RXDATA);
    // Pop deferred to the first cycle after the strobe so the head is stable.
    assign w_rx_pop    = r_pop_pend & memNotRead;
    assign w_tx_pop    = ~w_tx_empty & tx_ready;

    assign tx_valid = ~w_tx_empty;
    assign rx_ready = ~w_rx_full;
    assign irq      = r_irq;
    assign data     = w_rd_drive ? w_rd_val : 16'hzzzz;

    sync_fifo #(.WIDTH(16), .DEPTH(DEPTH), .CW(CW)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_tx_wr),
        .pop   (w_tx_pop),
        .flush (w_flush_tx),
        .wdata (w_tx_wdata),
        .head  (tx_data),
        .count (w_tx_count),
        .empty (w_tx_empty),
        .full  (w_tx_full)
    );

    sync_fifo #(.WIDTH(16), .DEPTH(DEPTH), .CW(CW)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_valid),
        .pop   (w_rx_pop),
        .flush (w_flush_rx),
        .wdata (rx_data),
        .head  (w_rx_head),
        .count (w_rx_count),
        .empty (w_rx_empty),
        .full  (w_rx_full)
    );

    always_comb begin
        w_rd_val = '0;
        case (address[1:0])
            REG_RXDATA: w_rd_val = w_rx_empty ? 16'h0000 : w_rx_head;
            REG_STATUS: begin
                w_rd_val[ST_RX_CNT +: 4] = sat_nib(32'(w_rx_count));
                w_rd_val[ST_TX_CNT +: 4] = sat_nib(32'(w_tx_count));
                w_rd_val[ST_RX_EMPTY]    = w_rx_empty;
                w_rd_val[ST_TX_FULL]     = w_tx_full;
                w_rd_val[ST_TX_OVF]      = r_tx_ovf;
                w_rd_val[ST_RX_UDF]      = r_rx_udf;
            end
            REG_CTRL: begin
                w_rd_val[CTRL_IRQ_RX]  = r_en_rx;
                w_rd_val[CTRL_IRQ_TXE] = r_en_txe;
            end
            default: w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_act   <= 1'b1;
            r_rd_act   <= 1'b1;
            r_pop_pend <= 1'b0;
            r_en_rx    <= 1'b0;
            r_en_txe   <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_rx_udf   <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_wr_act <= ~memNotWrite;
            r_rd_act <= ~memNotRead;
            if (w_ctrl_wr && !csl_n) begin
                r_en_rx  <= data[CTRL_IRQ_RX];
                r_en_txe <= data[CTRL_IRQ_TXE];
            end
            if (w_clr) begin
                r_tx_ovf <= 1'b0;
                r_rx_udf <= 1'b0;
            end
            if (w_tx_wr && w_tx_full) r_tx_ovf <= 1'b1;
            if (w_rd_start) begin
                if (w_rx_empty) r_rx_udf   <= 1'b1;
                else            r_pop_pend <= 1'b1;
            end else if (w_rx_pop) begin
                r_pop_pend <= 1'b0;
            end
            r_irq <= (r_en_rx & ~w_rx_empty) | (r_en_txe & w_tx_empty);
        end
    end

endmodule
